// File: rtl/dose_timer_pkg.sv
// Shared definitions for the dose timer: FSM state encoding, motor channel
// indices, display codes and the largest digit that produces a dose.
package dose_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [1:0] CH_R = 2'd2;
    localparam logic [1:0] CH_Y = 2'd1;
    localparam logic [1:0] CH_B = 2'd0;

    localparam logic [4:0] BLANK = 5'd16;
    localparam logic [4:0] DASH  = 5'd17;

    localparam int unsigned MAX_DIGIT = 9;

    // Channel index to motor / flag bit position ([2]=R, [1]=Y, [0]=B).
    function automatic logic [2:0] chan_onehot(input logic [1:0] ch);
        return 3'b001 << ch;
    endfunction

endpackage

// File: rtl/dose_timer_prescaler.sv
// Clearable free-running counter that divides the clock into dosing units;
// wrap_o pulses combinationally on the last tick of each unit while enabled.
module unit_prescaler #(
    parameter int unsigned TICKS_PER_UNIT = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic wrap_o
);

    localparam int unsigned CNT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_UNIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dose_timer.sv
// Converts the three latched colour digits into timed, one-at-a-time motor runs
// and returns a per-colour completion level to the colour-mixing FSM.
module dose_timer
    import dose_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 50_000_000,
    parameter int unsigned DIGIT_W        = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] dig_R,
    input  logic [DIGIT_W-1:0] dig_Y,
    input  logic [DIGIT_W-1:0] dig_B,
    input  logic [2:0]         Motores,
    output logic [2:0]         motor_drive,
    output logic               t_R,
    output logic               t_Y,
    output logic               t_B,
    output logic               busy,
    output logic               err
);

    state_e     state_q;
    logic [1:0] chan_q;
    logic [3:0] units_q;
    logic [2:0] drive_q;
    logic [2:0] done_q;
    logic       busy_q;
    logic       err_q;

    logic       req_single_d;
    logic       req_multi_d;
    logic [1:0] req_chan_d;
    logic [3:0] req_units_d;
    logic       chan_held_d;
    logic       unit_wrap;

    // Blank, dash and any other non-digit code doses nothing.
    function automatic logic [3:0] digit_units(input logic [DIGIT_W-1:0] dig);
        if (DIGIT_W'(MAX_DIGIT) < dig) begin
            return 4'd0;
        end
        return 4'(dig);
    endfunction

    always_comb begin
        req_single_d = 1'b0;
        req_multi_d  = 1'b0;
        req_chan_d   = CH_B;
        req_units_d  = 4'd0;
        case (Motores)
            3'b000: begin
            end
            3'b100: begin
                req_single_d = 1'b1;
                req_chan_d   = CH_R;
                req_units_d  = digit_units(dig_R);
            end
            3'b010: begin
                req_single_d = 1'b1;
                req_chan_d   = CH_Y;
                req_units_d  = digit_units(dig_Y);
            end
            3'b001: begin
                req_single_d = 1'b1;
                req_chan_d   = CH_B;
                req_units_d  = digit_units(dig_B);
            end
            default: begin
                req_multi_d = 1'b1;
            end
        endcase
        chan_held_d = Motores[chan_q];
    end

    unit_prescaler #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q == IDLE),
        .en_i   (state_q == RUN),
        .wrap_o (unit_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            chan_q  <= 2'd0;
            units_q <= 4'd0;
            drive_q <= 3'b000;
            done_q  <= 3'b000;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_multi_d) begin
                        err_q <= 1'b1;
                    end else if (req_single_d) begin
                        chan_q  <= req_chan_d;
                        units_q <= req_units_d;
                        if (req_units_d == 4'd0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                            drive_q <= chan_onehot(req_chan_d);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A dropped request wins over a coincident last-unit wrap.
                    if (!chan_held_d) begin
                        state_q <= IDLE;
                        drive_q <= 3'b000;
                        busy_q  <= 1'b0;
                    end else if (unit_wrap) begin
                        units_q <= units_q - 4'd1;
                        if (units_q == 4'd1) begin
                            state_q <= DONE;
                            drive_q <= 3'b000;
                            busy_q  <= 1'b0;
                            done_q  <= chan_onehot(chan_q);
                        end
                    end
                end
                DONE: begin
                    if (chan_held_d) begin
                        done_q <= chan_onehot(chan_q);
                    end else begin
                        done_q  <= 3'b000;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    drive_q <= 3'b000;
                    done_q  <= 3'b000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign motor_drive = drive_q;
    assign t_R         = done_q[CH_R];
    assign t_Y         = done_q[CH_Y];
    assign t_B         = done_q[CH_B];
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dose_timer.sv
// Self-checking bench for dose_timer with TICKS_PER_UNIT = 4: directed
// scenarios plus randomized requests compared against a closed-form timeline model.
module tb_dose_timer;

    localparam int TPU = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [4:0] dig_R   = 5'd0;
    logic [4:0] dig_Y   = 5'd0;
    logic [4:0] dig_B   = 5'd0;
    logic [2:0] Motores = 3'b000;
    logic [2:0] motor_drive;
    logic       t_R, t_Y, t_B, busy, err;

    int   n_checks = 0;
    int   n_err    = 0;
    logic exp_err  = 1'b0;

    dose_timer #(
        .TICKS_PER_UNIT(TPU),
        .DIGIT_W       (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dig_R      (dig_R),
        .dig_Y      (dig_Y),
        .dig_B      (dig_B),
        .Motores    (Motores),
        .motor_drive(motor_drive),
        .t_R        (t_R),
        .t_Y        (t_Y),
        .t_B        (t_B),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Request for channel ch seen at edges 0..hold-1, dropped at edge hold.
    // Returns the expected motor_drive and {t_R,t_Y,t_B} after edge k.
    function automatic void ref_expect(input int ch, input int digit, input int hold,
                                       input int k, output logic [2:0] drv,
                                       output logic [2:0] t);
        int  n;
        int  d;
        int  on_len;
        bit  on;
        bit  fl;
        n      = (digit > 9) ? 0 : digit;
        d      = n * TPU;
        on_len = (hold < d) ? hold : d;
        on     = (n > 0) && (k < on_len);
        if (n > 0) fl = (hold > d) && (k >= d) && (k < hold);
        else       fl = (k >= 1) && (k < hold);
        drv = on ? 3'(1 << ch) : 3'b000;
        t   = fl ? 3'(1 << ch) : 3'b000;
    endfunction

    task automatic set_digit(input int ch, input int digit);
        case (ch)
            2:       dig_R = 5'(digit);
            1:       dig_Y = 5'(digit);
            default: dig_B = 5'(digit);
        endcase
    endtask

    task automatic start_req(input int ch, input int digit);
        set_digit(ch, digit);
        Motores = 3'(1 << ch);
    endtask

    task automatic scramble_digits();
        dig_R = 5'($urandom);
        dig_Y = 5'($urandom);
        dig_B = 5'($urandom);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        Motores = 3'b100;
        dig_R   = 5'd3;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({motor_drive, t_R, t_Y, t_B, busy, err} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_hold outputs got %b exp %b", {motor_drive, t_R, t_Y, t_B, busy, err}, 8'b0);
        end
        Motores = 3'b000;
        reset   = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({motor_drive, t_R, t_Y, t_B, busy, err} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_release outputs got %b exp %b", {motor_drive, t_R, t_Y, t_B, busy, err}, 8'b0);
        end
    endtask

    task automatic test_red_run();
        logic [2:0] ed, et;
        start_req(2, 3);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            ref_expect(2, 3, 14, k, ed, et);
            n_checks++;
            if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                n_err++;
                $display("FAIL red_run k=%0d drive got %b exp %b t got %b exp %b busy %b err got %b exp %b",
                         k, motor_drive, ed, {t_R, t_Y, t_B}, et, busy, err, exp_err);
            end
            if (k == 0) scramble_digits();
            if (k == 13) begin
                dig_Y   = 5'd0;
                Motores = 3'b010;
            end
        end
        Motores = 3'b000;
        @(negedge clk);
        n_checks++;
        if (motor_drive !== 3'b000 || {t_R, t_Y, t_B} !== 3'b000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL red_handover_idle drive got %b t got %b busy got %b exp all 0",
                     motor_drive, {t_R, t_Y, t_B}, busy);
        end
    endtask

    task automatic test_zero_digit();
        int         codes[3] = '{0, 16, 17};
        logic [2:0] ed, et;
        foreach (codes[i]) begin
            start_req(1, codes[i]);
            for (int k = 0; k <= 3; k++) begin
                @(negedge clk);
                ref_expect(1, codes[i], 3, k, ed, et);
                n_checks++;
                if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                    n_err++;
                    $display("FAIL zero_digit code=%0d k=%0d drive got %b exp %b t got %b exp %b busy %b",
                             codes[i], k, motor_drive, ed, {t_R, t_Y, t_B}, et, busy);
                end
                if (k == 2) Motores = 3'b000;
            end
        end
    endtask

    task automatic test_sequence();
        int         chs[3]  = '{2, 1, 0};
        int         dgs[3]  = '{2, 1, 9};
        int         lens[3] = '{8, 4, 36};
        logic [2:0] ed, et;
        int         hold, pulse, rises;
        logic       prev_t;
        start_req(chs[0], dgs[0]);
        for (int i = 0; i < 3; i++) begin
            hold   = dgs[i] * TPU + 2;
            pulse  = 0;
            rises  = 0;
            prev_t = 1'b0;
            for (int k = 0; k <= hold; k++) begin
                @(negedge clk);
                ref_expect(chs[i], dgs[i], hold, k, ed, et);
                n_checks++;
                if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                    n_err++;
                    $display("FAIL sequence txn=%0d k=%0d drive got %b exp %b t got %b exp %b busy %b",
                             i, k, motor_drive, ed, {t_R, t_Y, t_B}, et, busy);
                end
                if (motor_drive != 3'b000) pulse++;
                if (({t_R, t_Y, t_B} != 3'b000) && !prev_t) rises++;
                prev_t = ({t_R, t_Y, t_B} != 3'b000);
                if (k == 0) scramble_digits();
                if (k == hold - 1) begin
                    if (i < 2) start_req(chs[i+1], dgs[i+1]);
                    else       Motores = 3'b000;
                end
            end
            n_checks++;
            if (pulse !== lens[i]) begin
                n_err++;
                $display("FAIL sequence_pulse txn=%0d length got %0d exp %0d", i, pulse, lens[i]);
            end
            n_checks++;
            if (rises !== 1) begin
                n_err++;
                $display("FAIL sequence_flag txn=%0d rises got %0d exp 1", i, rises);
            end
        end
    endtask

    task automatic test_abort();
        logic [2:0] ed, et;
        start_req(0, 5);
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            ref_expect(0, 5, 7, k, ed, et);
            n_checks++;
            if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                n_err++;
                $display("FAIL abort k=%0d drive got %b exp %b t got %b exp %b busy %b",
                         k, motor_drive, ed, {t_R, t_Y, t_B}, et, busy);
            end
            if (k == 6) Motores = 3'b000;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (motor_drive !== 3'b000 || {t_R, t_Y, t_B} !== 3'b000 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_idle k=%0d drive got %b t got %b busy got %b exp all 0",
                         k, motor_drive, {t_R, t_Y, t_B}, busy);
            end
        end
    endtask

    task automatic test_err();
        logic [2:0] ed, et;
        logic [2:0] bad[2] = '{3'b110, 3'b011};
        foreach (bad[i]) begin
            Motores = bad[i];
            @(negedge clk);
            exp_err = 1'b1;
            n_checks++;
            if (err !== 1'b1 || motor_drive !== 3'b000 || busy !== 1'b0 || {t_R, t_Y, t_B} !== 3'b000) begin
                n_err++;
                $display("FAIL multi_request req=%b err got %b exp 1 drive got %b exp 000", bad[i], err, motor_drive);
            end
        end
        Motores = 3'b000;
        @(negedge clk);
        start_req(2, 3);
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            ref_expect(2, 3, 13, k, ed, et);
            n_checks++;
            if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                n_err++;
                $display("FAIL err_then_run k=%0d drive got %b exp %b t got %b exp %b err got %b exp %b",
                         k, motor_drive, ed, {t_R, t_Y, t_B}, et, err, exp_err);
            end
            if (k == 12) Motores = 3'b000;
        end
    endtask

    task automatic test_reset_midrun();
        logic [2:0] ed, et;
        start_req(2, 3);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            ref_expect(2, 3, 100, k, ed, et);
            n_checks++;
            if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000)) begin
                n_err++;
                $display("FAIL midrun_pre k=%0d drive got %b exp %b t got %b exp %b",
                         k, motor_drive, ed, {t_R, t_Y, t_B}, et);
            end
        end
        #2 reset = 1'b0;
        #1;
        exp_err = 1'b0;
        n_checks++;
        if ({motor_drive, t_R, t_Y, t_B, busy, err} !== 8'b0) begin
            n_err++;
            $display("FAIL midrun_async_reset outputs got %b exp %b", {motor_drive, t_R, t_Y, t_B, busy, err}, 8'b0);
        end
        @(negedge clk);
        dig_R = 5'd3;
        reset = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            ref_expect(2, 3, 14, k, ed, et);
            n_checks++;
            if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                n_err++;
                $display("FAIL midrun_rerun k=%0d drive got %b exp %b t got %b exp %b err got %b exp %b",
                         k, motor_drive, ed, {t_R, t_Y, t_B}, et, err, exp_err);
            end
            if (k == 13) Motores = 3'b000;
        end
    endtask

    task automatic test_random();
        logic [2:0] ed, et;
        logic [2:0] bad[4] = '{3'b011, 3'b101, 3'b110, 3'b111};
        int         ch, digit, n, hold;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                Motores = bad[$urandom_range(0, 3)];
                @(negedge clk);
                exp_err = 1'b1;
                n_checks++;
                if (err !== 1'b1 || motor_drive !== 3'b000) begin
                    n_err++;
                    $display("FAIL random_multi txn=%0d err got %b exp 1 drive got %b exp 000", t, err, motor_drive);
                end
                Motores = 3'b000;
                @(negedge clk);
            end
            ch    = $urandom_range(0, 2);
            digit = $urandom_range(0, 31);
            n     = (digit > 9) ? 0 : digit;
            hold  = $urandom_range(1, n * TPU + 5);
            start_req(ch, digit);
            for (int k = 0; k <= hold; k++) begin
                @(negedge clk);
                ref_expect(ch, digit, hold, k, ed, et);
                n_checks++;
                if (motor_drive !== ed || {t_R, t_Y, t_B} !== et || busy !== (ed != 3'b000) || err !== exp_err) begin
                    n_err++;
                    $display("FAIL random txn=%0d ch=%0d dig=%0d hold=%0d k=%0d drive got %b exp %b t got %b exp %b err got %b exp %b",
                             t, ch, digit, hold, k, motor_drive, ed, {t_R, t_Y, t_B}, et, err, exp_err);
                end
                if (k == 0) scramble_digits();
                if (k == hold - 1) Motores = 3'b000;
            end
        end
    endtask

    initial begin
        test_reset();
        test_red_run();
        test_zero_digit();
        test_sequence();
        test_abort();
        test_err();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dose_timer.md
Name: dose_timer

Overview:
- Downstream of the colour-mixing FSM. Converts the three stored colour digits into timed motor runs.
- Drives one motor at a time and returns the t_R / t_Y / t_B completion flags that the FSM waits on in its carga_R / carga_Y / carga_B states.
- Motor run time equals digit × TICKS_PER_UNIT clock cycles.

Parameters:
- TICKS_PER_UNIT, 50_000_000, clock cycles per dosing unit (1 s at 50 MHz); set to 4 in simulation.
- DIGIT_W, 5, width of each colour digit code.
- MAX_DIGIT, 9, largest valid digit. Codes above this (16 = blank, 17 = dash) dose 0 units.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dig_R  in  DIGIT_W  red dose digit, held stable by the FSM during carga states
- dig_Y  in  DIGIT_W  yellow dose digit
- dig_B  in  DIGIT_W  blue dose digit
- Motores  in  3  one-hot request from the FSM: [2] = R, [1] = Y, [0] = B
- motor_drive  out  3  one-hot physical motor enable, same bit order
- t_R  out  1  red dose complete (level)
- t_Y  out  1  yellow dose complete (level)
- t_B  out  1  blue dose complete (level)
- busy  out  1  high in RUN
- err  out  1  sticky flag: more than one Motores bit was seen high in IDLE

Behaviour:
- Reset (async, reset = 0): state = IDLE; prescaler = 0; units = 0; chan = 0; motor_drive = 000; t_R = t_Y = t_B = 0; busy = 0; err = 0.
- All outputs are registered.
- Single shared timer: a prescaler counting 0..TICKS_PER_UNIT-1 and a units down-counter 4 bits wide. chan is a 2-bit index.
- IDLE:
  - Motores == 000: stay in IDLE.
  - Exactly one bit set: latch chan and that channel's digit. A digit > MAX_DIGIT loads 0. Clear the prescaler.
  - If the loaded units == 0, go to DONE. Otherwise go to RUN and set motor_drive = one-hot(chan) on the same edge.
  - More than one bit set: set err = 1 and stay in IDLE with motor_drive = 000. err clears only on reset.
- RUN:
  - The prescaler increments every cycle. When it reaches TICKS_PER_UNIT-1 it wraps to 0 and units decrements.
  - When units decrements from 1 to 0: clear motor_drive and go to DONE on the same edge. The motor is therefore high for exactly units × TICKS_PER_UNIT cycles.
  - If Motores[chan] drops (abort): clear motor_drive and go to IDLE. No done flag is raised.
  - Changes on the dig_* inputs during RUN are ignored, because the value was latched.
- DONE:
  - The t flag for chan is high. It holds while Motores[chan] = 1.
  - When Motores[chan] = 0, clear the flag and go to IDLE. The FSM's next request is then serviced one cycle later.
- Latency:
  - Request visible at edge 0 gives motor_drive high from edge 0 through edge N×T-1; the done flag rises at edge N×T.
  - For N = 0, the done flag rises at edge 1.
- Only one of t_R, t_Y, t_B is ever high. A t flag and motor_drive are never high together.
- busy = (state == RUN).

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10
  - channel indices: CH_R = 2, CH_Y = 1, CH_B = 0
  - display codes: BLANK = 5'd16, DASH = 5'd17
  - MAX_DIGIT
- One natural sub-module, unit_prescaler: a free-running, clearable counter with a wrap pulse, parameterised by TICKS_PER_UNIT.

Test Plan (TICKS_PER_UNIT = 4):
- dig_R = 3, Motores = 100 from cycle 0 → motor_drive = 100 for cycles 0–11; t_R = 1 from cycle 12; Motores → 010 clears t_R the next cycle.
- dig_Y = 0, Motores = 010 → motor_drive stays 000 and t_Y = 1 at cycle 1. Repeat with dig_Y = 16 (blank) and get the same result.
- Full sequence R = 2, Y = 1, B = 9 with the FSM model → drive pulses of 8, 4 and 36 cycles in order R, Y, B; each t flag raised once.
- Motores = 001 with dig_B = 5, dropped to 000 at cycle 6 → motor_drive = 000 at cycle 7; t_B never asserted; state IDLE.
- Motores = 110 in IDLE → err = 1, motor_drive = 000. A later valid 100 request still runs normally and err stays 1.
- reset pulled low at cycle 5 of a 3-unit run → all outputs 0 immediately (async). After release with Motores = 100 still held, a fresh full 12-cycle run starts.
